// File: rtl/ps2_cursor_pkg.sv
// Shared region codes, click FSM states and default screen/grid/hotspot
// geometry for the PS/2 cursor tracker.
package ps2_cursor_pkg;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_GRID = 2'd1;
  localparam logic [1:0] KIND_HOT  = 2'd2;

  localparam int DEF_POS_W      = 10;
  localparam int DEF_X_MAX      = 783;
  localparam int DEF_Y_MAX      = 583;
  localparam int DEF_HOME_X     = 384;
  localparam int DEF_HOME_Y     = 284;
  localparam int DEF_GRID_X0    = 272;
  localparam int DEF_GRID_Y0    = 172;
  localparam int DEF_CELL_SHIFT = 5;
  localparam int DEF_GRID_COLS  = 8;
  localparam int DEF_GRID_ROWS  = 8;
  localparam int DEF_IDX_W      = 6;
  localparam int DEF_NUM_HOT    = 2;

  // {x0,x1,y0,y1} per hotspot, hotspot 0 (retract) in the LSBs, hotspot 1 (retry) above it
  localparam logic [DEF_NUM_HOT*4*DEF_POS_W-1:0] DEF_HOT_RECTS = {
    10'd200, 10'd250, 10'd200, 10'd250,
    10'd100, 10'd150, 10'd200, 10'd250
  };

  typedef struct packed {
    logic [1:0]           kind;
    logic [DEF_IDX_W-1:0] idx;
  } region_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } click_state_t;

endpackage

// File: rtl/ps2_click_fsm.sv
// Per-button press/release tracker: pulses click when the release lands in
// the same non-empty region that was latched at press time.
module ps2_click_fsm
  import ps2_cursor_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             pkt_vld,
  input  logic             button,
  input  logic [IDX_W+1:0] region,
  output logic             click,
  output logic [IDX_W+1:0] click_region
);

  click_state_t     state, state_nxt;
  logic             prev_btn;
  logic [IDX_W+1:0] latched, latched_nxt;
  logic             fire;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      prev_btn     <= 1'b0;
      latched      <= '0;
      click        <= 1'b0;
      click_region <= '0;
    end else begin
      state        <= state_nxt;
      latched      <= latched_nxt;
      click        <= fire;
      click_region <= fire ? latched : '0;
      if (pkt_vld) prev_btn <= button;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pkt_vld) begin
      case (state)
        ST_IDLE:  if (button && !prev_btn) state_nxt = ST_ARMED;
        ST_ARMED: if (!button) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fire        = 1'b0;
    latched_nxt = latched;
    if (pkt_vld && state == ST_IDLE && button && !prev_btn)
      latched_nxt = region;
    if (pkt_vld && state == ST_ARMED && !button &&
        region == latched && region[IDX_W+1:IDX_W] != KIND_NONE)
      fire = 1'b1;
  end

endmodule

// File: rtl/ps2_cursor_tracker.sv
// Integrates PS/2 mouse deltas into a clamped cursor, decodes the cursor into
// a grid cell or hotspot, and turns same-region press/release into clicks.
module ps2_cursor_tracker
  import ps2_cursor_pkg::*;
#(
  parameter int POS_W       = DEF_POS_W,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int HOME_X      = DEF_HOME_X,
  parameter int HOME_Y      = DEF_HOME_Y,
  parameter int SPEED_SHIFT = 0,
  parameter int GRID_X0     = DEF_GRID_X0,
  parameter int GRID_Y0     = DEF_GRID_Y0,
  parameter int CELL_SHIFT  = DEF_CELL_SHIFT,
  parameter int GRID_COLS   = DEF_GRID_COLS,
  parameter int GRID_ROWS   = DEF_GRID_ROWS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int NUM_HOT     = DEF_NUM_HOT,
  parameter logic [NUM_HOT*4*POS_W-1:0] HOT_RECTS = DEF_HOT_RECTS
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               data_ready,
  input  logic [8:0]         x_increment,
  input  logic [8:0]         y_increment,
  input  logic               left_button,
  input  logic               right_button,
  output logic [POS_W-1:0]   cursor_x,
  output logic [POS_W-1:0]   cursor_y,
  output logic               in_grid,
  output logic [IDX_W-1:0]   cell_idx,
  output logic [NUM_HOT-1:0] hot_hover,
  output logic               left_click,
  output logic               right_click,
  output logic [1:0]         left_kind,
  output logic [1:0]         right_kind,
  output logic [IDX_W-1:0]   left_idx,
  output logic [IDX_W-1:0]   right_idx
);

  localparam int DW     = POS_W + 3;
  localparam int GRID_W = GRID_COLS << CELL_SHIFT;
  localparam int GRID_H = GRID_ROWS << CELL_SHIFT;

  function automatic logic signed [DW-1:0] scale_delta(input logic [8:0] inc);
    logic signed [DW-1:0] ext;
    ext = signed'({{(DW-9){inc[8]}}, inc});
    return ext <<< SPEED_SHIFT;
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [DW-1:0] v,
                                                 input int max_v);
    if (v < 0) return '0;
    if (int'(v) > max_v) return POS_W'(max_v);
    return POS_W'(v);
  endfunction

  function automatic int first_index(input logic [NUM_HOT-1:0] onehot);
    int n;
    n = 0;
    for (int i = 0; i < NUM_HOT; i++)
      if (onehot == (NUM_HOT'(1) << i)) n = i;
    return n;
  endfunction

  logic signed [DW-1:0] sx, sy;
  logic                 vld_p1, left_p1, right_p1;

  assign sx = signed'({3'b000, cursor_x}) + scale_delta(x_increment);
  assign sy = signed'({3'b000, cursor_y}) - scale_delta(y_increment);

  // Stage p0 -> p1: cursor integration; packet buttons follow as the packet-valid stage
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cursor_x <= POS_W'(HOME_X);
      cursor_y <= POS_W'(HOME_Y);
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= data_ready;
      if (data_ready) begin
        cursor_x <= clamp_pos(sx, X_MAX);
        cursor_y <= clamp_pos(sy, Y_MAX);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (data_ready) begin
      left_p1  <= left_button;
      right_p1 <= right_button;
    end
  end

  int               cx, cy;
  logic [NUM_HOT-1:0] hot_hit, hot_first;
  logic             grid_hit;
  logic [IDX_W+1:0] region_nxt;
  logic [IDX_W-1:0] cell_nxt;
  logic [NUM_HOT-1:0] hover_nxt;

  assign cx = int'(cursor_x);
  assign cy = int'(cursor_y);
  assign grid_hit = (cx >= GRID_X0) && (cx < GRID_X0 + GRID_W) &&
                    (cy >= GRID_Y0) && (cy < GRID_Y0 + GRID_H);

  for (genvar h = 0; h < NUM_HOT; h++) begin : g_hot
    localparam int BASE = h * 4 * POS_W;
    localparam int HX0  = int'(HOT_RECTS[BASE + 3*POS_W +: POS_W]);
    localparam int HX1  = int'(HOT_RECTS[BASE + 2*POS_W +: POS_W]);
    localparam int HY0  = int'(HOT_RECTS[BASE + POS_W +: POS_W]);
    localparam int HY1  = int'(HOT_RECTS[BASE +: POS_W]);
    assign hot_hit[h] = (cx >= HX0) && (cx <= HX1) && (cy >= HY0) && (cy <= HY1);
  end

  // lowest set bit wins on overlapping hotspots
  assign hot_first = hot_hit & (~hot_hit + NUM_HOT'(1));

  always_comb begin
    region_nxt = {KIND_NONE, {IDX_W{1'b0}}};
    cell_nxt   = '0;
    hover_nxt  = '0;
    if (grid_hit) begin
      cell_nxt   = IDX_W'(((cy - GRID_Y0) >> CELL_SHIFT) * GRID_COLS +
                          ((cx - GRID_X0) >> CELL_SHIFT));
      region_nxt = {KIND_GRID, cell_nxt};
    end else if (hot_hit != '0) begin
      hover_nxt  = hot_first;
      region_nxt = {KIND_HOT, IDX_W'(first_index(hot_first))};
    end
  end

  // Stage p1 -> p2: registered region outputs, aligned with the click pulses
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      in_grid   <= 1'b0;
      cell_idx  <= '0;
      hot_hover <= '0;
    end else begin
      in_grid   <= grid_hit;
      cell_idx  <= cell_nxt;
      hot_hover <= hover_nxt;
    end
  end

  logic [IDX_W+1:0] left_region, right_region;

  ps2_click_fsm #(.IDX_W(IDX_W)) u_left_fsm (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .pkt_vld      (vld_p1),
    .button       (left_p1),
    .region       (region_nxt),
    .click        (left_click),
    .click_region (left_region)
  );

  ps2_click_fsm #(.IDX_W(IDX_W)) u_right_fsm (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .pkt_vld      (vld_p1),
    .button       (right_p1),
    .region       (region_nxt),
    .click        (right_click),
    .click_region (right_region)
  );

  assign left_kind  = left_region[IDX_W+1:IDX_W];
  assign left_idx   = left_region[IDX_W-1:0];
  assign right_kind = right_region[IDX_W+1:IDX_W];
  assign right_idx  = right_region[IDX_W-1:0];

endmodule
